// File: rtl/id_pkg.sv
// Shared definitions for the instruction-decode stage.
// Holds the default datapath sizes and the hazard-reason encoding used by
// the stall logic in id_stage_pipe.
package id_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned REG_N_DEF  = 32;
  localparam int unsigned CTRL_W_DEF = 24;

  // Why the decode stage is refusing a new instruction this cycle.
  typedef enum logic [1:0] {
    HZ_NONE      = 2'd0,
    HZ_LOAD_USE  = 2'd1,
    HZ_RAW_NOFWD = 2'd2
  } hazard_e;

endpackage

// File: rtl/regfile_wf.sv
// Register file with two combinational read ports and one write port.
// A read of the address being written in the same cycle returns the write
// data (write-through). Entry 0 always reads as zero and ignores writes.
// All entries clear asynchronously on reset.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   i_we, i_waddr, i_wdata  write port
//   i_raddr_a / o_rdata_a   read port A
//   i_raddr_b / o_rdata_b   read port B
module regfile_wf #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_N  = 32,
  localparam int unsigned AW    = $clog2(REG_N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr_a,
  output logic [DATA_W-1:0] o_rdata_a,
  input  logic [AW-1:0]     i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_b
);

  logic [DATA_W-1:0] r_mem [REG_N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_N; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we && (i_waddr != '0)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_comb begin
    o_rdata_a = '0;
    if (i_raddr_a != '0) begin
      o_rdata_a = (i_we && (i_waddr == i_raddr_a)) ? i_wdata : r_mem[i_raddr_a];
    end
  end

  always_comb begin
    o_rdata_b = '0;
    if (i_raddr_b != '0) begin
      o_rdata_b = (i_we && (i_waddr == i_raddr_b)) ? i_wdata : r_mem[i_raddr_b];
    end
  end

endmodule

// File: rtl/id_stage_pipe.sv
// Instruction-decode stage with the ID/EX pipeline register.
// Reads operands (MEM bypass > WB write-through > register array), detects
// load-use and, when forwarding is disabled, all RAW hazards, and inserts
// bubbles on stall, idle input or flush.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   in_valid / in_ready              IF/ID handshake
//   in_rs, in_rt, in_rd              register addresses of presented instruction
//   in_imm16, in_pc, in_ctrl         immediate, PC, opaque control bundle
//   in_is_load, in_uses_rt           load flag, rt-is-a-source flag
//   mem_regwr, mem_dst, mem_data     MEM-stage result for bypass
//   wb_regwr, wb_ovf, wb_dst, wb_data register-file write port
//   flush                            kill ID and ID/EX contents
//   out_*                            registered ID/EX fields
module id_stage_pipe import id_pkg::*; #(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned REG_N  = REG_N_DEF,
  parameter int unsigned CTRL_W = CTRL_W_DEF,
  parameter int unsigned FWD_EN = 1,
  localparam int unsigned AW    = $clog2(REG_N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [AW-1:0]     in_rs,
  input  logic [AW-1:0]     in_rt,
  input  logic [AW-1:0]     in_rd,
  input  logic [15:0]       in_imm16,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              in_is_load,
  input  logic              in_uses_rt,
  input  logic              mem_regwr,
  input  logic [AW-1:0]     mem_dst,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              wb_regwr,
  input  logic              wb_ovf,
  input  logic [AW-1:0]     wb_dst,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_busA,
  output logic [DATA_W-1:0] out_busB,
  output logic [DATA_W-1:0] out_imm32,
  output logic [DATA_W-1:0] out_pc,
  output logic [AW-1:0]     out_rd,
  output logic [AW-1:0]     out_rt,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              out_is_load
);

  localparam bit FwdOn = (FWD_EN != 0);

  logic              r_valid;
  logic [DATA_W-1:0] r_busa;
  logic [DATA_W-1:0] r_busb;
  logic [DATA_W-1:0] r_imm;
  logic [DATA_W-1:0] r_pc;
  logic [AW-1:0]     r_rd;
  logic [AW-1:0]     r_rt;
  logic [CTRL_W-1:0] r_ctrl;
  logic              r_is_load;

  logic              w_rf_we;
  logic [DATA_W-1:0] w_rf_a;
  logic [DATA_W-1:0] w_rf_b;
  logic              w_byp_a;
  logic              w_byp_b;
  logic [DATA_W-1:0] w_opa;
  logic [DATA_W-1:0] w_opb;
  logic [DATA_W-1:0] w_imm_ext;
  logic [AW-1:0]     w_idex_dst;
  logic              w_load_use;
  logic              w_raw_ex;
  logic              w_raw_mem;
  hazard_e           w_reason;
  logic              w_stall;
  logic              w_take;

  // An overflowing result must not reach the architectural state.
  assign w_rf_we = wb_regwr & ~wb_ovf;

  regfile_wf #(
    .DATA_W (DATA_W),
    .REG_N  (REG_N)
  ) u_rf (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_we      (w_rf_we),
    .i_waddr   (wb_dst),
    .i_wdata   (wb_data),
    .i_raddr_a (in_rs),
    .o_rdata_a (w_rf_a),
    .i_raddr_b (in_rt),
    .o_rdata_b (w_rf_b)
  );

  // MEM bypass has priority over the write-through already done in the file.
  assign w_byp_a = FwdOn && mem_regwr && (mem_dst != '0) && (mem_dst == in_rs);
  assign w_byp_b = FwdOn && mem_regwr && (mem_dst != '0) && (mem_dst == in_rt);
  assign w_opa   = w_byp_a ? mem_data : w_rf_a;
  assign w_opb   = w_byp_b ? mem_data : w_rf_b;

  assign w_imm_ext = DATA_W'($signed(in_imm16));

  // Loads write rt; every other instruction carries its destination in rd
  // (the decoder routes rt into rd for immediate forms).
  assign w_idex_dst = r_is_load ? r_rt : r_rd;

  assign w_load_use = r_valid && r_is_load && (r_rt != '0) &&
                      ((r_rt == in_rs) || (in_uses_rt && (r_rt == in_rt)));
  assign w_raw_ex   = r_valid && (w_idex_dst != '0) &&
                      ((w_idex_dst == in_rs) || (in_uses_rt && (w_idex_dst == in_rt)));
  assign w_raw_mem  = mem_regwr && (mem_dst != '0) &&
                      ((mem_dst == in_rs) || (in_uses_rt && (mem_dst == in_rt)));

  always_comb begin
    w_reason = HZ_NONE;
    if (in_valid) begin
      if (w_load_use) begin
        w_reason = HZ_LOAD_USE;
      end else if (!FwdOn && (w_raw_ex || w_raw_mem)) begin
        w_reason = HZ_RAW_NOFWD;
      end
    end
  end

  // Flush wins over any stall raised in the same cycle.
  assign w_stall  = (w_reason != HZ_NONE) && !flush;
  assign in_ready = !w_stall || !rst_n;
  assign w_take   = in_valid && !w_stall && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_busa    <= '0;
      r_busb    <= '0;
      r_imm     <= '0;
      r_pc      <= '0;
      r_rd      <= '0;
      r_rt      <= '0;
      r_ctrl    <= '0;
      r_is_load <= 1'b0;
    end else if (w_take) begin
      r_valid   <= 1'b1;
      r_busa    <= w_opa;
      r_busb    <= w_opb;
      r_imm     <= w_imm_ext;
      r_pc      <= in_pc;
      r_rd      <= in_rd;
      r_rt      <= in_rt;
      r_ctrl    <= in_ctrl;
      r_is_load <= in_is_load;
    end else begin
      // Bubble: fully zeroed so no downstream enable in the control bundle fires.
      r_valid   <= 1'b0;
      r_busa    <= '0;
      r_busb    <= '0;
      r_imm     <= '0;
      r_pc      <= '0;
      r_rd      <= '0;
      r_rt      <= '0;
      r_ctrl    <= '0;
      r_is_load <= 1'b0;
    end
  end

  assign out_valid   = r_valid;
  assign out_busA    = r_busa;
  assign out_busB    = r_busb;
  assign out_imm32   = r_imm;
  assign out_pc      = r_pc;
  assign out_rd      = r_rd;
  assign out_rt      = r_rt;
  assign out_ctrl    = r_ctrl;
  assign out_is_load = r_is_load;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Two decode stages driven by one stimulus stream: A is the default build
// (32-bit, 32 registers, bypass on), B is 16-bit, 8 registers, bypass off.
// Each has its own reference model and scoreboard queue.
module tb_id_stage_pipe;

  localparam int unsigned CW = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          in_valid, in_is_load, in_uses_rt, mem_regwr, wb_regwr, wb_ovf, flush;
  logic [4:0]    in_rs, in_rt, in_rd, mem_dst, wb_dst;
  logic [15:0]   in_imm16;
  logic [31:0]   in_pc, mem_data, wb_data;
  logic [CW-1:0] in_ctrl;

  logic          a_ready, a_valid, a_ld;
  logic [31:0]   a_busa, a_busb, a_imm, a_pc;
  logic [4:0]    a_rd, a_rt;
  logic [CW-1:0] a_ctrl;

  logic          b_ready, b_valid, b_ld;
  logic [15:0]   b_busa, b_busb, b_imm, b_pc;
  logic [2:0]    b_rd, b_rt;
  logic [CW-1:0] b_ctrl;

  id_stage_pipe #(.DATA_W(32), .REG_N(32), .CTRL_W(CW), .FWD_EN(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_ready),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm16(in_imm16), .in_pc(in_pc),
    .in_ctrl(in_ctrl), .in_is_load(in_is_load), .in_uses_rt(in_uses_rt),
    .mem_regwr(mem_regwr), .mem_dst(mem_dst), .mem_data(mem_data),
    .wb_regwr(wb_regwr), .wb_ovf(wb_ovf), .wb_dst(wb_dst), .wb_data(wb_data),
    .flush(flush), .out_valid(a_valid), .out_busA(a_busa), .out_busB(a_busb),
    .out_imm32(a_imm), .out_pc(a_pc), .out_rd(a_rd), .out_rt(a_rt),
    .out_ctrl(a_ctrl), .out_is_load(a_ld)
  );

  id_stage_pipe #(.DATA_W(16), .REG_N(8), .CTRL_W(CW), .FWD_EN(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_ready),
    .in_rs(in_rs[2:0]), .in_rt(in_rt[2:0]), .in_rd(in_rd[2:0]), .in_imm16(in_imm16),
    .in_pc(in_pc[15:0]), .in_ctrl(in_ctrl), .in_is_load(in_is_load),
    .in_uses_rt(in_uses_rt), .mem_regwr(mem_regwr), .mem_dst(mem_dst[2:0]),
    .mem_data(mem_data[15:0]), .wb_regwr(wb_regwr), .wb_ovf(wb_ovf),
    .wb_dst(wb_dst[2:0]), .wb_data(wb_data[15:0]), .flush(flush),
    .out_valid(b_valid), .out_busA(b_busa), .out_busB(b_busb), .out_imm32(b_imm),
    .out_pc(b_pc), .out_rd(b_rd), .out_rt(b_rt), .out_ctrl(b_ctrl), .out_is_load(b_ld)
  );

  typedef struct {
    int            cyc;
    logic [31:0]   a, b, imm, pc;
    logic [4:0]    rd, rt;
    logic [CW-1:0] ctrl;
    bit            ld;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // Reference model: architectural register contents and the one
  // instruction each stage currently holds in ID/EX.
  logic [31:0] m_rf [2][32];
  bit          m_v [2];
  bit          m_ld [2];
  logic [4:0]  m_rt [2];
  logic [4:0]  m_dst [2];
  bit          m_take [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] msk(int k, logic [31:0] v);
    return (k == 1) ? (v & 32'h0000_FFFF) : v;
  endfunction

  function automatic bit hits(logic [4:0] d);
    return (d != 5'd0) && ((in_rs == d) || (in_uses_rt && (in_rt == d)));
  endfunction

  function automatic bit hazard(int k);
    bit lu, raw;
    lu  = m_v[k] && m_ld[k] && hits(m_rt[k]);
    raw = (k == 1) && ((m_v[k] && hits(m_dst[k])) || (mem_regwr && hits(mem_dst)));
    return in_valid && (lu || raw);
  endfunction

  // Newest value of a register as seen by an instruction in decode.
  function automatic logic [31:0] operand(int k, logic [4:0] src);
    if (src == 5'd0) return 32'd0;
    if (k == 0 && mem_regwr && mem_dst == src) return mem_data;
    if (wb_regwr && !wb_ovf && wb_dst == src) return msk(k, wb_data);
    return m_rf[k][src];
  endfunction

  function automatic void clear_model();
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 32; r++) m_rf[k][r] = 32'd0;
      m_v[k] = 0; m_ld[k] = 0; m_rt[k] = 5'd0; m_dst[k] = 5'd0; m_take[k] = 0;
    end
  endfunction

  // Inputs already driven; predict, push expectations, advance one clock.
  task automatic tick();
    bit hz, take;
    exp_t e;
    #1;
    for (int k = 0; k < 2; k++) begin
      hz = hazard(k);
      chk(k == 0 ? "a_in_ready" : "b_in_ready", k == 0 ? a_ready : b_ready,
          !rst_n || flush || !hz);
      take = rst_n && in_valid && !flush && !hz;
      m_take[k] = take;
      if (take) begin
        e.cyc  = cyc + 1;
        e.a    = operand(k, in_rs);
        e.b    = operand(k, in_rt);
        e.imm  = (k == 1) ? {16'h0, in_imm16} : {{16{in_imm16[15]}}, in_imm16};
        e.pc   = msk(k, in_pc);
        e.rd   = in_rd;
        e.rt   = in_rt;
        e.ctrl = in_ctrl;
        e.ld   = in_is_load;
        if (k == 0) q0.push_back(e); else q1.push_back(e);
      end
    end
    @(posedge clk);
    if (!rst_n) begin
      clear_model();
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_v[k]   = m_take[k];
        m_ld[k]  = m_take[k] && in_is_load;
        m_rt[k]  = in_rt;
        m_dst[k] = in_is_load ? in_rt : in_rd;
        if (wb_regwr && !wb_ovf && wb_dst != 5'd0) m_rf[k][wb_dst] = msk(k, wb_data);
      end
    end
    #1;
  endtask

  task automatic mon_one(input int k, input bit v, input logic [31:0] ba, input logic [31:0] bb,
                         input logic [31:0] im, input logic [31:0] pc, input logic [4:0] rd,
                         input logic [4:0] rt, input logic [CW-1:0] ct, input bit ld);
    exp_t e;
    int sz;
    string p;
    p  = (k == 0) ? "a_" : "b_";
    sz = (k == 0) ? q0.size() : q1.size();
    if (v) begin
      if (sz == 0) begin
        chk({p, "unexpected_output"}, 1, 0);
      end else begin
        if (k == 0) e = q0.pop_front(); else e = q1.pop_front();
        chk({p, "out_cycle"}, cyc, e.cyc);
        chk({p, "busA"}, ba, e.a);
        chk({p, "busB"}, bb, e.b);
        chk({p, "imm32"}, im, e.imm);
        chk({p, "pc"}, pc, e.pc);
        chk({p, "rd"}, rd, e.rd);
        chk({p, "rt"}, rt, e.rt);
        chk({p, "ctrl"}, ct, e.ctrl);
        chk({p, "is_load"}, ld, e.ld);
      end
    end else begin
      chk({p, "bubble_ctrl"}, ct, 0);
      if (sz != 0) begin
        e = (k == 0) ? q0[0] : q1[0];
        if (e.cyc <= cyc) begin
          chk({p, "missing_output_cycle"}, cyc, e.cyc);
          if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      mon_one(0, a_valid, a_busa, a_busb, a_imm, a_pc, a_rd, a_rt, a_ctrl, a_ld);
      mon_one(1, b_valid, {16'h0, b_busa}, {16'h0, b_busb}, {16'h0, b_imm}, {16'h0, b_pc},
              {2'b0, b_rd}, {2'b0, b_rt}, b_ctrl, b_ld);
    end
  end

  task automatic idle();
    in_valid = 0; in_is_load = 0; in_uses_rt = 0; flush = 0;
    in_rs = 0; in_rt = 0; in_rd = 0; in_imm16 = 0; in_pc = 0; in_ctrl = 0;
    mem_regwr = 0; mem_dst = 0; mem_data = 0;
    wb_regwr = 0; wb_ovf = 0; wb_dst = 0; wb_data = 0;
  endtask

  task automatic instr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [15:0] imm, input bit ld, input bit urt);
    in_valid = 1; in_rs = rs; in_rt = rt; in_rd = rd; in_imm16 = imm;
    in_is_load = ld; in_uses_rt = urt; in_pc = $urandom; in_ctrl = CW'($urandom) | 1;
  endtask

  task automatic reset_checks();
    chk("rst_a_valid", a_valid, 0);
    chk("rst_a_fields", {a_busa, a_busb} | {a_imm, a_pc}, 0);
    chk("rst_a_misc", {a_rd, a_rt, a_ctrl, a_ld}, 0);
    chk("rst_a_ready", a_ready, 1);
    chk("rst_b_valid", b_valid, 0);
    chk("rst_b_fields", {b_busa, b_busb, b_imm, b_pc}, 0);
    chk("rst_b_misc", {b_rd, b_rt, b_ctrl, b_ld}, 0);
    chk("rst_b_ready", b_ready, 1);
  endtask

  // Asynchronous reset: whatever ID/EX held is gone before it is observed.
  task automatic do_reset();
    rst_n = 0;
    #1;
    foreach (q0[i]) if (q0[i].cyc < cyc) chk("a_overdue_at_reset", q0[i].cyc, cyc);
    foreach (q1[i]) if (q1[i].cyc < cyc) chk("b_overdue_at_reset", q1[i].cyc, cyc);
    q0.delete();
    q1.delete();
    reset_checks();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hold;
    clear_model();
    idle();
    rst_n = 0;
    #2;
    reset_checks();
    repeat (3) tick();
    reset_checks();
    rst_n = 1;

    // Write-through into the same-cycle read, then an overflowing write.
    idle(); wb_regwr = 1; wb_dst = 5; wb_data = 32'h1234; instr(5, 0, 1, 16'h0010, 0, 0);
    tick();
    chk("wt_a_busA", a_busa, 32'h1234);
    chk("wt_b_busA", b_busa, 16'h1234);
    idle(); wb_regwr = 1; wb_ovf = 1; wb_dst = 5; wb_data = 32'hDEAD; tick();
    idle(); instr(5, 0, 1, 0, 0, 0); tick();
    chk("ovf_a_busA", a_busa, 32'h1234);

    // MEM bypass beats WB write-through.
    idle(); mem_regwr = 1; mem_dst = 3; mem_data = 32'hAAAA;
    wb_regwr = 1; wb_dst = 3; wb_data = 32'hBBBB; instr(0, 3, 1, 0, 0, 1);
    tick();
    chk("byp_a_busB", a_busb, 32'hAAAA);
    idle(); repeat (2) tick();

    // Load-use on r7: one stall, one bubble, then forwarded load data.
    instr(0, 7, 0, 0, 1, 0); tick();
    instr(7, 0, 4, 0, 0, 0); #1; chk("lu_a_ready", a_ready, 0); tick();
    chk("lu_a_bubble", a_valid, 0);
    mem_regwr = 1; mem_dst = 7; mem_data = 32'hCAFE_F00D; #1; chk("lu_a_ready2", a_ready, 1);
    tick();
    chk("lu_a_valid", a_valid, 1);
    chk("lu_a_busA", a_busa, 32'hCAFE_F00D);
    idle(); repeat (2) tick();

    // Flush during a load-use stall.
    instr(0, 7, 0, 0, 1, 0); tick();
    instr(7, 0, 4, 0, 0, 0); flush = 1; #1; chk("fl_a_ready", a_ready, 1); tick();
    chk("fl_a_valid", a_valid, 0);
    idle(); repeat (3) tick();

    // Register 0 ignores writes and MEM bypass.
    wb_regwr = 1; wb_dst = 0; wb_data = 32'hFFFF; tick();
    idle(); mem_regwr = 1; mem_dst = 0; mem_data = 32'h5555; instr(0, 0, 1, 0, 0, 1); tick();
    chk("r0_a_busA", a_busa, 0);
    chk("r0_a_busB", a_busb, 0);
    idle(); repeat (2) tick();

    // No-forwarding build: RAW on r2 stalls through EX and MEM.
    instr(0, 0, 2, 16'h8001, 0, 0); tick();
    chk("imm_b_trunc", b_imm, 16'h8001);
    chk("imm_a_sext", a_imm, 32'hFFFF_8001);
    instr(2, 0, 3, 0, 0, 0); #1; chk("raw_b_stall1", b_ready, 0); tick();
    mem_regwr = 1; mem_dst = 2; mem_data = 32'h99; #1; chk("raw_b_stall2", b_ready, 0); tick();
    mem_regwr = 0; wb_regwr = 1; wb_dst = 2; wb_data = 32'h77; #1; chk("raw_b_go", b_ready, 1);
    tick();
    chk("raw_b_busA", b_busa, 16'h77);
    idle(); repeat (2) tick();

    // Reset while stalled; the stalled instruction is re-presented afterwards.
    instr(0, 7, 0, 0, 1, 0); tick();
    instr(7, 5, 4, 0, 0, 1); #1; chk("rs_a_stall", a_ready, 0);
    do_reset();
    tick();
    rst_n = 1;
    tick();
    chk("rs_a_valid", a_valid, 1);
    chk("rs_a_busB", a_busb, 0);
    idle(); repeat (2) tick();

    // Random traffic; upstream holds an instruction until both stages take it.
    hold = 0;
    for (int n = 0; n < 1500; n++) begin
      if (!hold) begin
        in_valid   = ($urandom_range(0, 4) != 0);
        in_rs      = 5'($urandom_range(0, 7));
        in_rt      = 5'($urandom_range(0, 7));
        in_rd      = 5'($urandom_range(0, 7));
        in_is_load = ($urandom_range(0, 2) == 0);
        in_uses_rt = $urandom_range(0, 1);
        in_imm16   = 16'($urandom);
        in_pc      = $urandom;
        in_ctrl    = CW'($urandom);
      end
      flush     = ($urandom_range(0, 19) == 0);
      mem_regwr = $urandom_range(0, 1);
      mem_dst   = 5'($urandom_range(0, 7));
      mem_data  = $urandom;
      wb_regwr  = $urandom_range(0, 1);
      wb_ovf    = ($urandom_range(0, 7) == 0);
      wb_dst    = 5'($urandom_range(0, 7));
      wb_data   = $urandom;
      tick();
      hold = in_valid && !flush && !(m_take[0] && m_take[1]);
    end
    idle(); repeat (3) tick();
    chk("a_queue_drained", q0.size(), 0);
    chk("b_queue_drained", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/id_stage_pipe.md
ID_STAGE_PIPE -- requirements
Module: id_stage_pipe

Interface
REQ-001 Parameter DATA_W, 32, operand/data width in bits.
REQ-002 Parameter REG_N, 32, register count (power of 2, >=2); AW = log2(REG_N).
REQ-003 Parameter CTRL_W, 24, width of the opaque decoded-control bundle.
REQ-004 Parameter FWD_EN, 1, 1 = bypass network present, 0 = stall on every RAW hazard.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 in_valid / in_ready  input / output  1 / 1  IF/ID handshake; transfer when both are high.
REQ-008 in_rs, in_rt, in_rd  input  AW each  source and destination register addresses.
REQ-009 in_imm16, in_pc  input  16 / DATA_W  immediate and PC of the decoded instruction.
REQ-010 in_ctrl, in_is_load, in_uses_rt  input  CTRL_W / 1 / 1  control bundle, load flag, and rt-is-source flag.
REQ-011 mem_regwr, mem_dst, mem_data  input  1 / AW / DATA_W  MEM-stage result for bypass.
REQ-012 wb_regwr, wb_ovf, wb_dst, wb_data  input  1 / 1 / AW / DATA_W  register-file write port.
REQ-013 flush  input  1  branch/jump kill of the ID and ID/EX contents.
REQ-014 out_valid, out_busA, out_busB  output  1 / DATA_W / DATA_W  registered ID/EX operands.
REQ-015 out_imm32, out_pc, out_rd, out_rt, out_ctrl, out_is_load  output  registered ID/EX fields; out_imm32 is sign-extended.

Function
REQ-016 ID/EX fields SHALL load on transfer, giving one-cycle latency from acceptance to out_valid=1.
REQ-017 The register file SHALL write wb_data to wb_dst when wb_regwr=1 and wb_ovf=0.
REQ-018 Register 0 SHALL read as 0, and writes to it SHALL be ignored.
REQ-019 Operand read priority SHALL be MEM bypass (mem_regwr, matching nonzero dst), then WB write-through in the same cycle, then the array (FWD_EN=1).
REQ-020 Load-use hazard SHALL be detected when out_valid=1, out_is_load=1, out_rt!=0, and out_rt equals in_rs, or equals in_rt with in_uses_rt=1.
REQ-021 On a load-use hazard, in_ready SHALL be 0 and a bubble SHALL be inserted, giving out_valid=0 next cycle for exactly one cycle.
REQ-022 With FWD_EN=0, any nonzero source match against a valid ID/EX or MEM writer SHALL stall until the match clears.
REQ-023 WB write-through SHALL still apply when FWD_EN=0.
REQ-024 flush SHALL set out_valid=0 next cycle, discard the presented instruction, and force in_ready=1.
REQ-025 flush SHALL override a stall raised in the same cycle.
REQ-026 With in_valid=0 and no stall, a bubble SHALL be inserted (out_valid=0).
REQ-027 Bubble cycles SHALL hold out_ctrl at 0 so that no downstream write enable fires.
REQ-028 A stall SHALL persist while in_valid=1 and the hazard holds, with no instruction duplicated or lost.

Reset
REQ-029 While rst_n=0, out_valid SHALL be 0 and every ID/EX output SHALL be 0.
REQ-030 While rst_n=0, every register-file entry SHALL be 0 and in_ready SHALL be 1.
REQ-031 A reset asserted mid-stall SHALL clear all state, and the stalled instruction SHALL be re-presented by upstream.

Structure
REQ-032 Shared package id_pkg SHALL hold the default DATA_W/REG_N/CTRL_W and a hazard-reason enum (NONE, LOAD_USE, RAW_NOFWD).
REQ-033 Sub-module regfile_wf SHALL implement the register file: 2 read ports, 1 write port, write-through, reg0 hardwired to 0, async clear.
REQ-034 Hazard and bypass logic SHALL be combinational inside id_stage_pipe.

Verification
REQ-035 Write test: wb write r5=0x1234 with in_rs=5 in the same cycle -> out_busA=0x1234 next cycle; wb_ovf=1 on a write -> r5 unchanged.
REQ-036 MEM bypass test: mem_dst=3, mem_data=0xAAAA, wb_dst=3, wb_data=0xBBBB, in_rt=3 -> out_busB=0xAAAA.
REQ-037 Load-use test: lw r7 in ID/EX, next instruction with in_rs=7 -> in_ready=0 for 1 cycle, one bubble, then out_busA = forwarded mem_data.
REQ-038 Flush test: flush during a load-use stall -> in_ready=1, out_valid=0 next cycle, no later duplicate of the stalled instruction.
REQ-039 Register 0 test: write r0=0xFFFF, then read rs=0 -> out_busA=0; MEM bypass with mem_dst=0 is ignored.
REQ-040 Parameter test: FWD_EN=0, DATA_W=16, REG_N=8 -> RAW on r2 stalls 2 cycles; out_imm32 of in_imm16=0x8001 is 0xFFFF8001 truncated to 0x8001.
